// File: rtl/zmux_ctrl_pkg.sv
// Shared types and constants for the zmux select controller.
// Holds the controller state enum, the minimum legal guard length and the stats counter width.
package zmux_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        DWELL = 2'd2
    } ctrlStateT;

    localparam int GUARD_MIN = 2;
    localparam int STATS_W   = 16;

endpackage

// File: rtl/zdwell_counter.sv
// Loadable up/down counter with hold input and terminal-count flag.
// Used by zmux_switch_ctrl for both the dwell count and the guard count.
module zdwell_counter #(
    parameter int W = 16
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iLoad,
    input  logic [W-1:0] iLoadVal,
    input  logic         iHold,
    input  logic         iDown,
    input  logic [W-1:0] iTerm,
    output logic         oTc
);

    logic [W-1:0] cntReg;

    // Load has priority over hold so a restart always takes effect.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            cntReg <= '0;
        end else if (iLoad) begin
            cntReg <= iLoadVal;
        end else if (!iHold) begin
            cntReg <= iDown ? (cntReg - W'(1)) : (cntReg + W'(1));
        end
    end

    assign oTc = (cntReg == iTerm);

endmodule

// File: rtl/zmux_switch_ctrl.sv
// Break-before-make select controller for the photon-detector 2:1 mux (auto round-robin or manual).
// Defining ZMUX_SWITCH_CTRL_STATS_EN adds the 16-bit oSwitchCnt output counting completed switches.
module zmux_switch_ctrl
    import zmux_ctrl_pkg::*;
#(
    parameter int DWELL_W      = 16,
    parameter int GUARD_CYCLES = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iEn,
    input  logic               iMode,
    input  logic               iManSel,
    input  logic [DWELL_W-1:0] iDwell,
    input  logic               iHold,
    output logic               oSel,
    output logic               oBlank,
    output logic               oSwitchPulse
`ifdef ZMUX_SWITCH_CTRL_STATS_EN
    ,
    output logic [STATS_W-1:0] oSwitchCnt
`endif
);

    localparam int GUARD_W = (GUARD_CYCLES > 2) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

    if (GUARD_CYCLES < GUARD_MIN) begin : gGuardRangeCheck
        $error("zmux_switch_ctrl: GUARD_CYCLES must be at least %0d", GUARD_MIN);
    end

    ctrlStateT          stateReg;
    logic               selReg;
    logic               blankReg;
    logic               pulseReg;
    logic               targetReg;
    logic               modeReg;
    logic               guardFirstReg;
    logic [DWELL_W-1:0] dwellReg;
    logic [DWELL_W-1:0] dwellTerm;
    logic               dwellTc;
    logic               guardTc;
    logic               modeChange;

    // A latched dwell of 0 behaves as 1, so both terminate at count 0.
    assign dwellTerm  = (dwellReg == '0) ? '0 : (dwellReg - DWELL_W'(1));
    assign modeChange = (iMode != modeReg);

    zdwell_counter #(.W(DWELL_W)) uDwellCnt (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   ((stateReg != DWELL) || modeChange),
        .iLoadVal('0),
        .iHold   (iHold || !iMode),
        .iDown   (1'b0),
        .iTerm   (dwellTerm),
        .oTc     (dwellTc)
    );

    zdwell_counter #(.W(GUARD_W)) uGuardCnt (
        .iClk    (iClk),
        .iRst    (iRst),
        .iLoad   (stateReg != GUARD),
        .iLoadVal('0),
        .iHold   (1'b0),
        .iDown   (1'b0),
        .iTerm   (GUARD_LAST),
        .oTc     (guardTc)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            stateReg      <= IDLE;
            selReg        <= 1'b0;
            blankReg      <= 1'b1;
            pulseReg      <= 1'b0;
            targetReg     <= 1'b0;
            modeReg       <= 1'b0;
            guardFirstReg <= 1'b0;
            dwellReg      <= '0;
        end else begin
            pulseReg <= 1'b0;
            modeReg  <= iMode;
            if (!iEn) begin
                // Abort anything in flight; the select keeps its current value.
                stateReg <= IDLE;
                blankReg <= 1'b1;
            end else begin
                case (stateReg)
                    IDLE: begin
                        stateReg      <= GUARD;
                        blankReg      <= 1'b1;
                        guardFirstReg <= 1'b1;
                        targetReg     <= iMode ? selReg : iManSel;
                    end
                    GUARD: begin
                        // Select moves only after one full blanked cycle.
                        if (guardFirstReg) begin
                            selReg        <= targetReg;
                            guardFirstReg <= 1'b0;
                        end
                        if (guardTc) begin
                            stateReg <= DWELL;
                            blankReg <= 1'b0;
                            pulseReg <= 1'b1;
                            dwellReg <= iDwell;
                        end
                    end
                    DWELL: begin
                        if (modeChange) begin
                            dwellReg <= iDwell;
                        end else if (iMode) begin
                            if (!iHold && dwellTc) begin
                                stateReg      <= GUARD;
                                blankReg      <= 1'b1;
                                guardFirstReg <= 1'b1;
                                targetReg     <= ~selReg;
                            end
                        end else if (!iHold && (iManSel != selReg)) begin
                            stateReg      <= GUARD;
                            blankReg      <= 1'b1;
                            guardFirstReg <= 1'b1;
                            targetReg     <= iManSel;
                        end
                    end
                    default: begin
                        stateReg <= IDLE;
                        blankReg <= 1'b1;
                    end
                endcase
            end
        end
    end

`ifdef ZMUX_SWITCH_CTRL_STATS_EN
    logic [STATS_W-1:0] switchCntReg;

    // Counts on the same edge that raises oSwitchPulse; wraps naturally.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            switchCntReg <= '0;
        end else if (iEn && (stateReg == GUARD) && guardTc) begin
            switchCntReg <= switchCntReg + STATS_W'(1);
        end
    end

    assign oSwitchCnt = switchCntReg;
`endif

    assign oSel         = selReg;
    assign oBlank       = blankReg;
    assign oSwitchPulse = pulseReg;

endmodule

// File: tb/tb_zmux_switch_ctrl.sv
// Randomized self-checking bench for zmux_switch_ctrl against a phase/countdown reference model.
// Also checks oSwitchCnt when ZMUX_SWITCH_CTRL_STATS_EN is defined.
module tb_zmux_switch_ctrl;

    localparam int DW    = 16;
    localparam int GUARD = 4;

    logic          iClk    = 1'b0;
    logic          iRst    = 1'b1;
    logic          iEn     = 1'b0;
    logic          iMode   = 1'b0;
    logic          iManSel = 1'b0;
    logic          iHold   = 1'b0;
    logic [DW-1:0] iDwell  = '0;
    logic          oSel;
    logic          oBlank;
    logic          oSwitchPulse;
`ifdef ZMUX_SWITCH_CTRL_STATS_EN
    logic [15:0]   oSwitchCnt;
`endif

    int nTests    = 0;
    int nFail     = 0;
    int cycleNum  = 0;
    int dutPulses = 0;

    // Reference model: phase 0 idle, 1 guard, 2 dwell.
    int mPhase;
    int mGuardIdx;
    int mElapsed;
    int mDwellLen;
    int mSwitches;
    bit mSel;
    bit mBlank;
    bit mPulse;
    bit mPend;
    bit mPrevMode;

    int   expPeriod = 0;
    int   lastPulse = -1;
    logic lastPulseSel = 1'b0;
    logic obsSel, obsBlank, obsPulse;

    int            n, p0, kind, segLen;
    logic          rMan, rMode, rEn;
    logic [DW-1:0] rDw;

    zmux_switch_ctrl #(
        .DWELL_W     (DW),
        .GUARD_CYCLES(GUARD)
    ) dut (
        .iClk        (iClk),
        .iRst        (iRst),
        .iEn         (iEn),
        .iMode       (iMode),
        .iManSel     (iManSel),
        .iDwell      (iDwell),
        .iHold       (iHold),
        .oSel        (oSel),
        .oBlank      (oBlank),
        .oSwitchPulse(oSwitchPulse)
`ifdef ZMUX_SWITCH_CTRL_STATS_EN
        ,
        .oSwitchCnt  (oSwitchCnt)
`endif
    );

    always #5 iClk = ~iClk;

    task automatic checkEq(input string tag, input int got, input int exp);
        nTests++;
        if (got != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cycleNum);
        end
    endtask

    task automatic modelReset();
        mPhase    = 0;
        mGuardIdx = 0;
        mElapsed  = 0;
        mDwellLen = 1;
        mSel      = 1'b0;
        mBlank    = 1'b1;
        mPulse    = 1'b0;
        mPend     = 1'b0;
        mPrevMode = 1'b0;
        mSwitches = 0;
    endtask

    task automatic startGuard(input bit target);
        mPhase    = 1;
        mGuardIdx = 1;
        mPend     = target;
        mBlank    = 1'b1;
    endtask

    // Advances the model across one clock edge with the inputs sampled there.
    task automatic modelStep(input bit en, input bit mode, input bit man,
                             input logic [DW-1:0] dw, input bit hold);
        mPulse = 1'b0;
        if (!en) begin
            mPhase = 0;
            mBlank = 1'b1;
        end else if (mPhase == 0) begin
            startGuard(mode ? mSel : man);
        end else if (mPhase == 1) begin
            if (mGuardIdx == 1) mSel = mPend;
            if (mGuardIdx == GUARD) begin
                mPhase    = 2;
                mBlank    = 1'b0;
                mPulse    = 1'b1;
                mElapsed  = 0;
                mDwellLen = (dw == 0) ? 1 : int'(dw);
                mSwitches++;
            end else begin
                mGuardIdx++;
            end
        end else begin
            if (mode != mPrevMode) begin
                mElapsed  = 0;
                mDwellLen = (dw == 0) ? 1 : int'(dw);
            end else if (mode) begin
                if (!hold) begin
                    mElapsed++;
                    if (mElapsed >= mDwellLen) startGuard(!mSel);
                end
            end else if (!hold && (man != mSel)) begin
                startGuard(man);
            end
        end
        mPrevMode = mode;
    endtask

    // Checks the current cycle's outputs, then drives inputs for the next edge.
    task automatic runCycle(input logic en, input logic mode, input logic man,
                            input logic [DW-1:0] dw, input logic hold);
        @(negedge iClk);
        obsSel   = oSel;
        obsBlank = oBlank;
        obsPulse = oSwitchPulse;
        checkEq("sel", int'(oSel), int'(mSel));
        checkEq("blank", int'(oBlank), int'(mBlank));
        checkEq("pulse", int'(oSwitchPulse), int'(mPulse));
`ifdef ZMUX_SWITCH_CTRL_STATS_EN
        checkEq("switchCnt", int'(oSwitchCnt), mSwitches % 65536);
`endif
        if (oSwitchPulse) begin
            dutPulses++;
            if (expPeriod != 0 && lastPulse >= 0) begin
                checkEq("period", cycleNum - lastPulse, expPeriod);
                checkEq("alternate", int'(oSel), int'(!lastPulseSel));
            end
            lastPulse    = cycleNum;
            lastPulseSel = oSel;
        end
        iEn     = en;
        iMode   = mode;
        iManSel = man;
        iDwell  = dw;
        iHold   = hold;
        modelStep(en, mode, man, dw, hold);
        cycleNum++;
    endtask

    task automatic startPeriodCheck(input int period);
        expPeriod = period;
        lastPulse = -1;
    endtask

    task automatic releaseReset();
        @(negedge iClk);
        iRst = 1'b0;
        modelStep(iEn, iMode, iManSel, iDwell, iHold);
    endtask

    task automatic asyncReset();
        @(negedge iClk);
        #2 iRst = 1'b1;
        #1;
        checkEq("rst_sel", int'(oSel), 0);
        checkEq("rst_blank", int'(oBlank), 1);
        checkEq("rst_pulse", int'(oSwitchPulse), 0);
        modelReset();
        @(negedge iClk);
        releaseReset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycleNum);
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
        repeat (2) @(negedge iClk);
        releaseReset();
        repeat (3) runCycle(1'b0, 1'b0, 1'b0, DW'(0), 1'b0);
        $display("[TB] reset/idle: blank held with iEn low");

        // Auto round-robin, dwell 10: 10 clear + 4 blank per switch.
        runCycle(1'b1, 1'b1, 1'b0, DW'(10), 1'b0);
        startPeriodCheck(10 + GUARD);
        repeat (60) runCycle(1'b1, 1'b1, 1'b0, DW'(10), 1'b0);
        $display("[TB] auto dwell 10: pulses %0d", dutPulses);

        // Async reset mid-dwell with select on channel 1.
        startPeriodCheck(0);
        n = 0;
        while (n < 200 && !(mPhase == 2 && mSel)) begin
            runCycle(1'b1, 1'b1, 1'b0, DW'(10), 1'b0);
            n++;
        end
        if (n >= 200) checkEq("reach_dwell_sel1", 0, 1);
        asyncReset();
        $display("[TB] async reset mid-dwell after %0d cycles", n);

        // Dwell 0 behaves as 1: period 5.
        runCycle(1'b1, 1'b1, 1'b0, DW'(0), 1'b0);
        startPeriodCheck(1 + GUARD);
        repeat (30) runCycle(1'b1, 1'b1, 1'b0, DW'(0), 1'b0);
        startPeriodCheck(0);
        $display("[TB] auto dwell 0: pulses %0d", dutPulses);

        // Manual request latency.
        n = 0;
        while (n < 200 && !(n >= 2 && mPhase == 2 && !mSel)) begin
            runCycle(1'b1, 1'b0, 1'b0, DW'(5), 1'b0);
            n++;
        end
        if (n >= 200) checkEq("reach_manual", 0, 1);
        runCycle(1'b1, 1'b0, 1'b1, DW'(5), 1'b0);
        runCycle(1'b1, 1'b0, 1'b1, DW'(5), 1'b0);
        checkEq("man_blank_rise", int'(obsBlank), 1);
        checkEq("man_sel_before", int'(obsSel), 0);
        runCycle(1'b1, 1'b0, 1'b1, DW'(5), 1'b0);
        checkEq("man_sel_after", int'(obsSel), 1);
        repeat (2) runCycle(1'b1, 1'b0, 1'b1, DW'(5), 1'b0);
        runCycle(1'b1, 1'b0, 1'b1, DW'(5), 1'b0);
        checkEq("man_unblank", int'(obsBlank), 0);
        checkEq("man_pulse", int'(obsPulse), 1);
        $display("[TB] manual switch 0->1");

        // Hold at count 3 of dwell 8 for 20 cycles.
        n = 0;
        while (n < 300 && !(mPhase == 2 && mDwellLen == 8 && mElapsed == 3)) begin
            runCycle(1'b1, 1'b1, 1'b0, DW'(8), 1'b0);
            n++;
        end
        if (n >= 300) checkEq("reach_hold", 0, 1);
        p0 = dutPulses;
        repeat (20) runCycle(1'b1, 1'b1, 1'b0, DW'(8), 1'b1);
        checkEq("hold_no_switch", dutPulses - p0, 0);
        checkEq("hold_no_blank", int'(obsBlank), 0);
        repeat (5) runCycle(1'b1, 1'b1, 1'b0, DW'(8), 1'b0);
        checkEq("hold_pre_blank", int'(obsBlank), 0);
        runCycle(1'b1, 1'b1, 1'b0, DW'(8), 1'b0);
        checkEq("hold_blank_rise", int'(obsBlank), 1);
        $display("[TB] hold at count 3 for 20 cycles");

        // Abort during guard cycle 2.
        n = 0;
        while (n < 100 && !(mPhase == 1 && mGuardIdx == 2)) begin
            runCycle(1'b1, 1'b1, 1'b0, DW'(3), 1'b0);
            n++;
        end
        if (n >= 100) checkEq("reach_guard2", 0, 1);
        p0 = dutPulses;
        repeat (5) runCycle(1'b0, 1'b1, 1'b0, DW'(3), 1'b0);
        checkEq("abort_blank", int'(obsBlank), 1);
        checkEq("abort_no_pulse", dutPulses - p0, 0);
        $display("[TB] abort in guard cycle 2");

        for (int seg = 0; seg < 40; seg++) begin
            kind   = $urandom_range(0, 3);
            segLen = $urandom_range(15, 60);
            rDw    = DW'($urandom_range(0, 12));
            rMan   = 1'b0;
            rMode  = 1'b1;
            rEn    = 1'b1;
            p0     = dutPulses;
            startPeriodCheck(0);
            for (int c = 0; c < segLen; c++) begin
                case (kind)
                    0: runCycle(1'b1, 1'b1, rMan, rDw, 1'b0);
                    1: runCycle(1'b1, 1'b1, rMan, rDw, $urandom_range(0, 7) == 0);
                    2: begin
                        if ($urandom_range(0, 7) == 0) rMan = !rMan;
                        runCycle(1'b1, 1'b0, rMan, rDw, $urandom_range(0, 5) == 0);
                    end
                    default: begin
                        if ($urandom_range(0, 9) == 0) rMode = !rMode;
                        if ($urandom_range(0, 3) == 0) rMan = 1'($urandom_range(0, 1));
                        if ($urandom_range(0, 7) == 0) rDw = DW'($urandom_range(0, 12));
                        rEn = ($urandom_range(0, 9) != 0);
                        runCycle(rEn, rMode, rMan, rDw, $urandom_range(0, 4) == 0);
                    end
                endcase
                if (c == 0 && kind == 0) startPeriodCheck(((rDw == 0) ? 1 : int'(rDw)) + GUARD);
            end
            startPeriodCheck(0);
            $display("[TB] seg %0d kind %0d dwell %0d cycles %0d pulses %0d",
                     seg, kind, rDw, segLen, dutPulses - p0);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/zmux_switch_ctrl.md
# zmux_switch_ctrl

Controller that drives the select line of the 2:1 signal multiplexer in the photon-detector processing chain. It decides when the mux switches between input channel 0 and channel 1, either on a timed round-robin or on a manual request. Every change is break-before-make: a blanking window is asserted first so downstream counters discard the switching transient. It sits between the control-register block and the mux; the mux is instantiated outside this block.

## Interface
- `DWELL_W`, default 16: width of the dwell-time input and the dwell counter.
- `GUARD_CYCLES`, default 4: blanking length per switch, in clocks; legal range is 2 or more (elaboration error otherwise).
- `iClk`, input, 1: the single clock.
- `iRst`, input, 1: reset; asynchronous and active-high.
- `iEn`, input, 1: enables switching; when low the output is blanked.
- `iMode`, input, 1: 0 = manual, 1 = auto round-robin.
- `iManSel`, input, 1: requested channel in manual mode.
- `iDwell`, input, `DWELL_W`: auto-mode dwell time in clocks; a value of 0 is treated as 1.
- `iHold`, input, 1: freezes the dwell counter and blocks new switches.
- `oSel`, output, 1: mux select; 0 = channel 0, 1 = channel 1.
- `oBlank`, output, 1: high while the mux output must be ignored.
- `oSwitchPulse`, output, 1: one-clock pulse on the first unblanked cycle after a guard.

## Operation
- **States:** IDLE, GUARD, DWELL.
- **Reset values:** state IDLE, `oSel` 0, `oBlank` 1, `oSwitchPulse` 0, dwell counter 0, guard counter 0.
- **IDLE:**
  - `oBlank` is 1 and `oSel` holds its value.
  - When `iEn` is 1, go to GUARD with target = `iManSel` in manual mode, or the current `oSel` in auto mode.
- **GUARD:**
  - `oBlank` is 1 for exactly `GUARD_CYCLES` clocks.
  - `oSel` takes the target value on the clock edge ending the first guard cycle, so the blank always leads the select change.
  - `iHold` and `iManSel` are ignored here; changes are evaluated in DWELL.
  - After the last guard cycle, go to DWELL.
- **DWELL:**
  - On entry, `oBlank` goes to 0, `oSwitchPulse` is 1 for one clock, the dwell counter clears and `iDwell` is latched.
- **Auto mode (in DWELL):**
  - The counter increments each clock unless `iHold` is high.
  - When the counter reaches latched dwell − 1 with `iHold` low, go to GUARD with target = `~oSel`.
- **Manual mode (in DWELL):**
  - When `iManSel` ≠ `oSel` and `iHold` is low, go to GUARD with target = `iManSel`.
  - If `iManSel` returns to `oSel` before that check, no switch occurs.
- **Mode change in DWELL:** when `iMode` changes, the counter clears and the dwell restarts; any manual mismatch is handled from the next cycle.
- **`iEn` low in any state:** go to IDLE on the next edge. A guard in progress is aborted; `oSel` keeps whatever value it already has.
- **Counter width:** the dwell counter is `DWELL_W` bits wide and cannot overflow, because it is compared against the latched dwell.

## Timing
- The cycle numbers below start at the first edge where `iEn` = 1 is sampled. `GUARD_CYCLES` = 4.
- **Enable to data:**
  - Cycles 1–4: GUARD, with `oBlank` = 1.
  - Cycle 5: DWELL, with `oBlank` = 0 and `oSwitchPulse` = 1.
- **Auto switch, `iDwell` = N:**
  - DWELL lasts N cycles.
  - The next GUARD starts on cycle N+1 of DWELL.
  - `oSel` flips one cycle after `oBlank` rises.
  - `oBlank` falls 4 cycles after it rose.
- **Manual request:** registered one cycle after the mismatch is seen, so `oBlank` rises 1 clock after `iManSel` changes.
- **Combined latency:** worst case from request to an unblanked new channel is 1 + `GUARD_CYCLES` clocks.
- **Output register:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **Macro:** `ZMUX_SWITCH_CTRL_STATS_EN`.
- **When defined:**
  - Adds output `oSwitchCnt` (16 bits), which increments on every `oSwitchPulse`.
  - The count wraps from 0xFFFF to 0x0000.
  - Reset value is 0; it is not cleared by `iEn`.
- **When undefined:** the port and its counter are absent; all other behaviour is identical.

## Structure
- **Package `zmux_ctrl_pkg`:** holds the state enum (IDLE, GUARD, DWELL), the constant `GUARD_MIN` = 2, and the stats counter width 16.
- **Sub-module `zdwell_counter`:** loadable down/up counter with hold input and terminal-count flag. It is reused for both the dwell count and the guard count.

## Test plan
- **Reset:** assert `iRst` mid-DWELL with `oSel` = 1 → asynchronously `oSel` = 0, `oBlank` = 1, `oSwitchPulse` = 0; state is IDLE.
- **Auto round-robin:** `iMode` = 1, `iDwell` = 10, `iEn` = 1 → `oBlank` low for 10 cycles, then high for 4; `oSel` toggles 0→1→0 one cycle after each blank rise; `oSwitchPulse` fires once per switch.
- **`iDwell` = 0 in auto mode:** DWELL lasts 1 cycle and the period is 5 clocks.
- **Manual switch:** `iMode` = 0, set `iManSel` = 1 in DWELL with `oSel` = 0 → `oBlank` rises next clock and `oSel` = 1 one clock later; `oBlank` is low 5 clocks after the request.
- **Hold in auto mode, `iDwell` = 8:** `iHold` = 1 for 20 cycles at count 3 → no switch during the hold; the switch occurs 5 cycles after `iHold` drops (remaining counts 3..7).
- **Abort and stats:** drop `iEn` in GUARD cycle 2 → IDLE next clock, `oBlank` stays 1, no `oSwitchPulse`. With `ZMUX_SWITCH_CTRL_STATS_EN` defined and 65 536 switches, `oSwitchCnt` wraps to 0.
